// File: rtl/msg_scan_ctrl.sv
// GO/STOP button debounce, two-state mode FSM and 4-digit letter scan for the S/t/o/P/G/O decoder.
// Optional build macro MSG_BLINK_EN blanks the STOP message on alternate BLINK_DIV half-periods.
module msg_scan_ctrl #(
   parameter int REFRESH_DIV     = 50000,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int BLINK_DIV       = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_go,
   input  logic       btn_stop,
   output logic [3:0] code,
   output logic [3:0] an,
   output logic       mode
);
   localparam int RW = $clog2(REFRESH_DIV);
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int BTN_GO   = 0;
   localparam int BTN_STOP = 1;
   localparam logic [3:0] CODE_BLANK = 4'hF;

   typedef enum logic {ST_STOP = 1'b0, ST_GO = 1'b1} mode_t;

   logic [1:0]    btn_raw_s;
   logic [1:0]    sync1_q, sync2_q, stable_q, stable_dly_q, press_q;
   logic [DW-1:0] db_cnt_q [2];
   mode_t         state_q;
   logic [RW-1:0] ref_q;
   logic [1:0]    idx_q;
   logic [3:0]    code_q, an_q, code_d;
   logic          blank_s;

   assign btn_raw_s = {btn_stop, btn_go};

   // Synchronize, debounce and edge-detect both buttons; press is a one-cycle pulse after the stable rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= 2'b00;
         sync2_q      <= 2'b00;
         stable_q     <= 2'b00;
         stable_dly_q <= 2'b00;
         press_q      <= 2'b00;
         for (int b = 0; b < 2; b++) begin
            db_cnt_q[b] <= '0;
         end
      end else begin
         sync1_q      <= btn_raw_s;
         sync2_q      <= sync1_q;
         stable_dly_q <= stable_q;
         press_q      <= stable_q & ~stable_dly_q;
         for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != stable_q[b]) begin
               if (db_cnt_q[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
                  stable_q[b] <= sync2_q[b];
                  db_cnt_q[b] <= '0;
               end else begin
                  db_cnt_q[b] <= db_cnt_q[b] + DW'(1);
               end
            end else begin
               db_cnt_q[b] <= '0;
            end
         end
      end
   end

   // Mode FSM: STOP has priority over GO when both pulses coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_STOP;
      end else begin
         case (state_q)
            ST_STOP: begin
               if (press_q[BTN_STOP]) begin
                  state_q <= ST_STOP;
               end else if (press_q[BTN_GO]) begin
                  state_q <= ST_GO;
               end else begin
                  state_q <= ST_STOP;
               end
            end
            ST_GO: begin
               if (press_q[BTN_STOP]) begin
                  state_q <= ST_STOP;
               end else begin
                  state_q <= ST_GO;
               end
            end
            default: state_q <= ST_STOP;
         endcase
      end
   end

   // Refresh divider and digit slot index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_q <= '0;
         idx_q <= 2'd0;
      end else if (ref_q == RW'(REFRESH_DIV - 1)) begin
         ref_q <= '0;
         idx_q <= idx_q + 2'd1;
      end else begin
         ref_q <= ref_q + RW'(1);
         idx_q <= idx_q;
      end
   end

`ifdef MSG_BLINK_EN
   localparam int BW = $clog2(2 * BLINK_DIV);
   logic [BW-1:0] blink_q;

   // Blink phase counter; held at zero in GO so every STOP entry starts on the visible half.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_q <= '0;
      end else if (state_q == ST_GO) begin
         blink_q <= '0;
      end else if (blink_q == BW'(2 * BLINK_DIV - 1)) begin
         blink_q <= '0;
      end else begin
         blink_q <= blink_q + BW'(1);
      end
   end

   assign blank_s = (state_q == ST_STOP) && (blink_q >= BW'(BLINK_DIV));
`else
   // Steady display; BLINK_DIV is still referenced so both builds share one parameter list.
   assign blank_s = 1'b0 & (BLINK_DIV == 0);
`endif

   // Letter map per slot, listed digit0 first.
   always_comb begin
      code_d = CODE_BLANK;
      if (blank_s) begin
         code_d = CODE_BLANK;
      end else if (state_q == ST_GO) begin
         case (idx_q)
            2'd0:    code_d = 4'h5;
            2'd1:    code_d = 4'h4;
            default: code_d = CODE_BLANK;
         endcase
      end else begin
         case (idx_q)
            2'd0:    code_d = 4'h3;
            2'd1:    code_d = 4'h2;
            2'd2:    code_d = 4'h1;
            2'd3:    code_d = 4'h0;
            default: code_d = CODE_BLANK;
         endcase
      end
   end

   // Registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q <= CODE_BLANK;
         an_q   <= 4'b1111;
      end else begin
         code_q <= code_d;
         an_q   <= ~(4'b0001 << idx_q);
      end
   end

   assign code = code_q;
   assign an   = an_q;
   assign mode = state_q;

endmodule

// File: tb/tb_msg_scan_ctrl.sv
// Directed bench for msg_scan_ctrl with REFRESH_DIV=4, DEBOUNCE_CYCLES=3, BLINK_DIV=8.
module tb_msg_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_go;
   logic       btn_stop;
   logic [3:0] code;
   logic [3:0] an;
   logic       mode;

   int checks   = 0;
   int failures = 0;
   int ecnt     = 0;

   localparam logic [3:0] AN_TAB   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   localparam logic [3:0] STOP_TAB [4] = '{4'h3, 4'h2, 4'h1, 4'h0};
   localparam logic [3:0] GO_TAB   [4] = '{4'h5, 4'h4, 4'hF, 4'hF};

   msg_scan_ctrl #(
      .REFRESH_DIV(4),
      .DEBOUNCE_CYCLES(3),
      .BLINK_DIV(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_go(btn_go),
      .btn_stop(btn_stop),
      .code(code),
      .an(an),
      .mode(mode)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      ecnt++;
   endtask

   // Slot whose outputs are visible after edge e (outputs lag the index by one clock).
   function automatic int slot(int e);
      return ((e - 1) / 4) % 4;
   endfunction

   function automatic logic [3:0] exp_stop(int e);
`ifdef MSG_BLINK_EN
      if (((e - 1) % 16) >= 8) return 4'hF;
`endif
      return STOP_TAB[slot(e)];
   endfunction

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ecnt  = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; btn_go = 1'b0; btn_stop = 1'b0;
      #12;
      checks++; if (an !== 4'b1111) begin failures++; $display("FAIL reset_an got=%b exp=1111", an); end
      checks++; if (code !== 4'hF) begin failures++; $display("FAIL reset_code got=%h exp=f", code); end
      checks++; if (mode !== 1'b0) begin failures++; $display("FAIL reset_mode got=%b exp=0", mode); end
      release_reset();
   endtask

   task automatic test_scan();
      for (int k = 1; k <= 20; k++) begin
         tick();
         checks++;
         if (an !== AN_TAB[slot(ecnt)] || code !== exp_stop(ecnt)) begin
            failures++;
            $display("FAIL scan edge=%0d an=%b code=%h exp_an=%b exp_code=%h",
                     ecnt, an, code, AN_TAB[slot(ecnt)], exp_stop(ecnt));
         end
      end
   endtask

   task automatic test_glitch();
      btn_go = 1'b1;
      tick(); tick();
      btn_go = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         checks++;
         if (mode !== 1'b0) begin failures++; $display("FAIL glitch k=%0d mode=%b exp=0", k, mode); end
      end
   endtask

   task automatic test_go_press();
      btn_go = 1'b1;
      for (int r = 1; r <= 7; r++) begin
         tick();
         checks++;
         if (mode !== (r == 7)) begin
            failures++; $display("FAIL go_press edge=%0d mode=%b exp=%b", r, mode, (r == 7));
         end
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (an !== AN_TAB[slot(ecnt)] || code !== GO_TAB[slot(ecnt)]) begin
            failures++;
            $display("FAIL go_map edge=%0d an=%b code=%h exp_an=%b exp_code=%h",
                     ecnt, an, code, AN_TAB[slot(ecnt)], GO_TAB[slot(ecnt)]);
         end
      end
      btn_go = 1'b0;
      repeat (10) tick();
      checks++; if (mode !== 1'b1) begin failures++; $display("FAIL go_release mode=%b exp=1", mode); end
      btn_go = 1'b1;
      repeat (10) tick();
      checks++; if (mode !== 1'b1) begin failures++; $display("FAIL go_in_go mode=%b exp=1", mode); end
      btn_go = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_both();
      btn_go = 1'b1; btn_stop = 1'b1;
      for (int r = 1; r <= 7; r++) begin
         tick();
         checks++;
         if (mode !== (r < 7)) begin
            failures++; $display("FAIL both edge=%0d mode=%b exp=%b", r, mode, (r < 7));
         end
      end
      btn_go = 1'b0; btn_stop = 1'b0;
      repeat (10) tick();
      btn_stop = 1'b1;
      repeat (10) tick();
      checks++; if (mode !== 1'b0) begin failures++; $display("FAIL stop_in_stop mode=%b exp=0", mode); end
      btn_stop = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_reset_mid();
      btn_go = 1'b1;
      repeat (10) tick();
      checks++; if (mode !== 1'b1) begin failures++; $display("FAIL pre_reset_go mode=%b exp=1", mode); end
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (an !== 4'b1111) begin failures++; $display("FAIL mid_reset_an got=%b exp=1111", an); end
      checks++; if (code !== 4'hF) begin failures++; $display("FAIL mid_reset_code got=%h exp=f", code); end
      checks++; if (mode !== 1'b0) begin failures++; $display("FAIL mid_reset_mode got=%b exp=0", mode); end
      release_reset();
      for (int r = 1; r <= 7; r++) begin
         tick();
         checks++;
         if (mode !== (r == 7)) begin
            failures++; $display("FAIL requalify edge=%0d mode=%b exp=%b", r, mode, (r == 7));
         end
      end
      tick();
      checks++;
      if (an !== 4'b1101 || code !== 4'h4) begin
         failures++; $display("FAIL requalify_map an=%b code=%h exp_an=1101 exp_code=4", an, code);
      end
   endtask

   task automatic test_blink();
      int blanks = 0;
      int exp_blanks;
      btn_go = 1'b0;
      rst_n  = 1'b0;
      #2;
      release_reset();
      for (int k = 1; k <= 32; k++) begin
         tick();
         if (code === 4'hF) blanks++;
         checks++;
         if (an !== AN_TAB[slot(ecnt)] || code !== exp_stop(ecnt)) begin
            failures++;
            $display("FAIL blink edge=%0d an=%b code=%h exp_an=%b exp_code=%h",
                     ecnt, an, code, AN_TAB[slot(ecnt)], exp_stop(ecnt));
         end
      end
`ifdef MSG_BLINK_EN
      exp_blanks = 16;
`else
      exp_blanks = 0;
`endif
      checks++;
      if (blanks != exp_blanks) begin
         failures++; $display("FAIL blink_count got=%0d exp=%0d", blanks, exp_blanks);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_glitch();
      test_go_press();
      test_both();
      test_reset_mid();
      test_blink();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
